// File: rtl/ctrl_frame_rx_parser.sv
// ctrl_frame_rx_parser: AXIS control-frame receiver for slot-ID, sim-start and
// time-sync frames, with runt/oversize/tuser validation and saturating
// good/error frame counters.
module ctrl_frame_rx_parser #(
  parameter logic [15:0] P_SLOT_ID_TYPE   = 16'hff03,
  parameter logic [15:0] P_SIM_START      = 16'hff0a,
  parameter logic [15:0] P_TIME_TYPE      = 16'hff05,
  parameter logic [7:0]  P_TS_CODE        = 8'h66,
  parameter logic [7:0]  P_STD_CODE       = 8'h88,
  parameter logic [7:0]  P_RET_CODE       = 8'h55,
  parameter int unsigned P_SLOT_ID_W      = 3,
  parameter int unsigned P_MAX_BEATS      = 8,
  parameter bit          P_COMMIT_ON_LAST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   s_ctrl_rx_axis_tvalid,
  input  logic [63:0]            s_ctrl_rx_axis_tdata,
  input  logic                   s_ctrl_rx_axis_tlast,
  input  logic [7:0]             s_ctrl_rx_axis_tkeep,
  input  logic                   s_ctrl_rx_axis_tuser,
  output logic [P_SLOT_ID_W-1:0] o_cur_slot_id,
  output logic                   o_syn_start,
  output logic                   o_sim_start,
  output logic [63:0]            o_recv_time_stamp,
  output logic                   o_recv_ts_valid,
  output logic [63:0]            o_recv_std_time,
  output logic                   o_recv_std_valid,
  output logic [63:0]            o_recv_return_ts,
  output logic                   o_recv_return_valid,
  output logic [15:0]            o_frame_cnt,
  output logic [15:0]            o_err_cnt
);

  localparam int unsigned LP_CNT_W = 8;
  localparam logic [LP_CNT_W-1:0] LP_LAST_BEAT = LP_CNT_W'(P_MAX_BEATS - 1);
  localparam logic [LP_CNT_W-1:0] LP_TIME_BEAT = LP_CNT_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DROP} state_t;
  typedef enum logic [2:0] {K_NONE, K_SYN, K_SIM, K_TS, K_STD, K_RET} kind_t;

  state_t                 state_q, state_d;
  logic [LP_CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  kind_t                  kind_q, kind_d;
  logic [P_SLOT_ID_W-1:0] slot_sh_q, slot_sh_d;
  logic [63:0]            time_sh_q, time_sh_d;

  logic [P_SLOT_ID_W-1:0] cur_slot_id_q, cur_slot_id_d;
  logic                   syn_start_q, syn_start_d;
  logic                   sim_start_q, sim_start_d;
  logic [63:0]            ts_q, ts_d;
  logic                   ts_valid_q, ts_valid_d;
  logic [63:0]            std_q, std_d;
  logic                   std_valid_q, std_valid_d;
  logic [63:0]            ret_q, ret_d;
  logic                   ret_valid_q, ret_valid_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [15:0]            err_cnt_q, err_cnt_d;

  kind_t                  dec_kind;
  kind_t                  fire_kind;
  logic [P_SLOT_ID_W-1:0] fire_slot;
  logic [63:0]            fire_time;
  logic                   frame_good;
  logic                   frame_bad;

  // tkeep carries no meaning here: a tlast beat ends the frame whatever its byte enables
  logic unused_tkeep;
  assign unused_tkeep = ^s_ctrl_rx_axis_tkeep;

  // Classify the current beat as if it were beat1 (type and sub-code)
  always_comb begin
    dec_kind = K_NONE;
    if (s_ctrl_rx_axis_tdata[31:16] == P_SLOT_ID_TYPE) begin
      dec_kind = K_SYN;
    end else if (s_ctrl_rx_axis_tdata[31:16] == P_SIM_START) begin
      dec_kind = K_SIM;
    end else if (s_ctrl_rx_axis_tdata[31:16] == P_TIME_TYPE) begin
      if (s_ctrl_rx_axis_tdata[7:0] == P_TS_CODE) begin
        dec_kind = K_TS;
      end else if (s_ctrl_rx_axis_tdata[7:0] == P_STD_CODE) begin
        dec_kind = K_STD;
      end else if (s_ctrl_rx_axis_tdata[7:0] == P_RET_CODE) begin
        dec_kind = K_RET;
      end
    end
  end

  // Frame FSM: beat tracking, frame verdict and which pulse (if any) to issue
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    kind_d     = kind_q;
    slot_sh_d  = slot_sh_q;
    time_sh_d  = time_sh_q;
    fire_kind  = K_NONE;
    fire_slot  = slot_sh_q;
    fire_time  = time_sh_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    if (s_ctrl_rx_axis_tvalid) begin
      case (state_q)
        S_IDLE: begin
          if (s_ctrl_rx_axis_tlast) begin
            frame_bad  = 1'b1;
            beat_cnt_d = '0;
          end else begin
            state_d    = S_HDR;
            beat_cnt_d = LP_CNT_W'(1);
          end
        end

        S_HDR: begin
          kind_d    = dec_kind;
          slot_sh_d = s_ctrl_rx_axis_tdata[P_SLOT_ID_W-1:0];
          fire_slot = s_ctrl_rx_axis_tdata[P_SLOT_ID_W-1:0];
          if (!P_COMMIT_ON_LAST && (dec_kind == K_SYN || dec_kind == K_SIM)) begin
            fire_kind = dec_kind;
          end
          if (s_ctrl_rx_axis_tlast) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            // Only slot-ID and sim-start frames may be 2 beats long
            if ((dec_kind == K_SYN || dec_kind == K_SIM) && !s_ctrl_rx_axis_tuser) begin
              frame_good = 1'b1;
              if (P_COMMIT_ON_LAST) begin
                fire_kind = dec_kind;
              end
            end else begin
              frame_bad = 1'b1;
            end
          end else begin
            state_d    = S_BODY;
            beat_cnt_d = LP_CNT_W'(2);
          end
        end

        S_BODY: begin
          beat_cnt_d = LP_CNT_W'(beat_cnt_q + LP_CNT_W'(1));
          if (beat_cnt_q == LP_TIME_BEAT) begin
            time_sh_d = s_ctrl_rx_axis_tdata;
            fire_time = s_ctrl_rx_axis_tdata;
            if (!P_COMMIT_ON_LAST && (kind_q == K_TS || kind_q == K_STD || kind_q == K_RET)) begin
              fire_kind = kind_q;
            end
          end
          if (s_ctrl_rx_axis_tlast) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            if (s_ctrl_rx_axis_tuser) begin
              frame_bad = 1'b1;
            end else begin
              frame_good = 1'b1;
              if (P_COMMIT_ON_LAST) begin
                fire_kind = kind_q;
              end
            end
          end else if (beat_cnt_q == LP_LAST_BEAT) begin
            state_d = S_DROP;
          end
        end

        S_DROP: begin
          if (s_ctrl_rx_axis_tlast) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            frame_bad  = 1'b1;
          end
        end

        default: begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  // Output pulses, held values and saturating counters
  always_comb begin
    syn_start_d   = (fire_kind == K_SYN);
    sim_start_d   = (fire_kind == K_SIM);
    ts_valid_d    = (fire_kind == K_TS);
    std_valid_d   = (fire_kind == K_STD);
    ret_valid_d   = (fire_kind == K_RET);
    cur_slot_id_d = (fire_kind == K_SYN) ? fire_slot : cur_slot_id_q;
    ts_d          = (fire_kind == K_TS)  ? fire_time : ts_q;
    std_d         = (fire_kind == K_STD) ? fire_time : std_q;
    ret_d         = (fire_kind == K_RET) ? fire_time : ret_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    if (frame_good && frame_cnt_q != 16'hffff) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (frame_bad && err_cnt_q != 16'hffff) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // State, shadow and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      beat_cnt_q    <= '0;
      kind_q        <= K_NONE;
      slot_sh_q     <= '0;
      time_sh_q     <= '0;
      cur_slot_id_q <= '0;
      syn_start_q   <= 1'b0;
      sim_start_q   <= 1'b0;
      ts_q          <= '0;
      ts_valid_q    <= 1'b0;
      std_q         <= '0;
      std_valid_q   <= 1'b0;
      ret_q         <= '0;
      ret_valid_q   <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      kind_q        <= kind_d;
      slot_sh_q     <= slot_sh_d;
      time_sh_q     <= time_sh_d;
      cur_slot_id_q <= cur_slot_id_d;
      syn_start_q   <= syn_start_d;
      sim_start_q   <= sim_start_d;
      ts_q          <= ts_d;
      ts_valid_q    <= ts_valid_d;
      std_q         <= std_d;
      std_valid_q   <= std_valid_d;
      ret_q         <= ret_d;
      ret_valid_q   <= ret_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign o_cur_slot_id       = cur_slot_id_q;
  assign o_syn_start         = syn_start_q;
  assign o_sim_start         = sim_start_q;
  assign o_recv_time_stamp   = ts_q;
  assign o_recv_ts_valid     = ts_valid_q;
  assign o_recv_std_time     = std_q;
  assign o_recv_std_valid    = std_valid_q;
  assign o_recv_return_ts    = ret_q;
  assign o_recv_return_valid = ret_valid_q;
  assign o_frame_cnt         = frame_cnt_q;
  assign o_err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_ctrl_frame_rx_parser.sv
// Bench for ctrl_frame_rx_parser: commit-on-last and cut-through instances
// share one AXIS stimulus and are checked against a frame-level model.
module tb_ctrl_frame_rx_parser;

  localparam int unsigned SW   = 3;
  localparam int          MAXB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tlast, tuser;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  logic [SW-1:0] c_slot, t_slot;
  logic          c_syn, c_sim, c_tsv, c_stdv, c_retv;
  logic          t_syn, t_sim, t_tsv, t_stdv, t_retv;
  logic [63:0]   c_ts, c_std, c_ret, t_ts, t_std, t_ret;
  logic [15:0]   c_fc, c_ec, t_fc, t_ec;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: index 0 = commit instance, 1 = cut-through instance
  logic [SW-1:0] m_slot [2];
  logic [63:0]   m_ts [2];
  logic [63:0]   m_std [2];
  logic [63:0]   m_ret [2];
  int            m_fc, m_ec;

  // expected / observed pulses (kind 1..5, edge number)
  int xk0[$], xt0[$], xk1[$], xt1[$];
  int ok0[$], ot0[$], ok1[$], ot1[$];

  typedef struct {
    int          n;
    logic [63:0] b1;
    logic [63:0] b2;
    bit          tu;
    bit          good;
    int          kind;
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_frame_rx_parser #(.P_SLOT_ID_W(SW), .P_MAX_BEATS(MAXB), .P_COMMIT_ON_LAST(1'b1)) dut_c (
    .i_clk(clk), .i_rst(rst),
    .s_ctrl_rx_axis_tvalid(tvalid), .s_ctrl_rx_axis_tdata(tdata), .s_ctrl_rx_axis_tlast(tlast),
    .s_ctrl_rx_axis_tkeep(tkeep), .s_ctrl_rx_axis_tuser(tuser),
    .o_cur_slot_id(c_slot), .o_syn_start(c_syn), .o_sim_start(c_sim),
    .o_recv_time_stamp(c_ts), .o_recv_ts_valid(c_tsv), .o_recv_std_time(c_std),
    .o_recv_std_valid(c_stdv), .o_recv_return_ts(c_ret), .o_recv_return_valid(c_retv),
    .o_frame_cnt(c_fc), .o_err_cnt(c_ec));

  ctrl_frame_rx_parser #(.P_SLOT_ID_W(SW), .P_MAX_BEATS(MAXB), .P_COMMIT_ON_LAST(1'b0)) dut_t (
    .i_clk(clk), .i_rst(rst),
    .s_ctrl_rx_axis_tvalid(tvalid), .s_ctrl_rx_axis_tdata(tdata), .s_ctrl_rx_axis_tlast(tlast),
    .s_ctrl_rx_axis_tkeep(tkeep), .s_ctrl_rx_axis_tuser(tuser),
    .o_cur_slot_id(t_slot), .o_syn_start(t_syn), .o_sim_start(t_sim),
    .o_recv_time_stamp(t_ts), .o_recv_ts_valid(t_tsv), .o_recv_std_time(t_std),
    .o_recv_std_valid(t_stdv), .o_recv_return_ts(t_ret), .o_recv_return_valid(t_retv),
    .o_frame_cnt(t_fc), .o_err_cnt(t_ec));

  logic [4:0] pv0, pv1;
  assign pv0 = {c_retv, c_stdv, c_tsv, c_sim, c_syn};
  assign pv1 = {t_retv, t_stdv, t_tsv, t_sim, t_syn};

  // record every cycle a pulse is high
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 5; k++) begin
        if (pv0[k]) begin ok0.push_back(k + 1); ot0.push_back(cyc); end
        if (pv1[k]) begin ok1.push_back(k + 1); ot1.push_back(cyc); end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // frame-level rules: kind from type/sub-code, verdict from length and tuser
  task automatic model(input int n, input logic [63:0] b1, input bit tu,
                       output bit good, output int kind);
    int minlen;
    kind = 0;
    if (b1[31:16] == 16'hff03) kind = 1;
    else if (b1[31:16] == 16'hff0a) kind = 2;
    else if (b1[31:16] == 16'hff05) begin
      if (b1[7:0] == 8'h66) kind = 3;
      else if (b1[7:0] == 8'h88) kind = 4;
      else if (b1[7:0] == 8'h55) kind = 5;
    end
    minlen = (b1[31:16] == 16'hff03 || b1[31:16] == 16'hff0a) ? 2 : 3;
    good = (n >= minlen) && (n <= MAXB) && !tu;
  endtask

  task automatic upd(input int m, input int kind, input logic [63:0] b1, input logic [63:0] b2);
    case (kind)
      1: m_slot[m] = b1[SW-1:0];
      3: m_ts[m]   = b2;
      4: m_std[m]  = b2;
      5: m_ret[m]  = b2;
      default: ;
    endcase
  endtask

  task automatic send_frame(input int n, input logic [63:0] b1, input logic [63:0] b2,
                            input bit tu, input bit gaps, input bit good, input int kind);
    int e1, e2, el;
    e1 = 0; e2 = 0; el = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          tvalid = 1'b0;
          tlast  = $urandom_range(0, 1);
          tdata  = {$urandom, $urandom};
        end
      end
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = (i == 1) ? b1 : (i == 2) ? b2 : {$urandom, $urandom};
      tlast  = (i == n - 1);
      tuser  = (i == n - 1) ? tu : 1'($urandom_range(0, 1));
      tkeep  = (i == n - 1 && $urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if (i == 1) e1 = cyc + 1;
      if (i == 2) e2 = cyc + 1;
      if (i == n - 1) el = cyc + 1;
    end
    if (good) begin
      if (m_fc < 16'hffff) m_fc++;
    end else begin
      if (m_ec < 16'hffff) m_ec++;
    end
    if (good && kind != 0) begin
      xk0.push_back(kind); xt0.push_back(el); upd(0, kind, b1, b2);
    end
    if ((kind == 1 || kind == 2) && n >= 2) begin
      xk1.push_back(kind); xt1.push_back(e1); upd(1, kind, b1, b2);
    end else if (kind >= 3 && n >= 3) begin
      xk1.push_back(kind); xt1.push_back(e2); upd(1, kind, b1, b2);
    end
  endtask

  task automatic cmp_q(input string nm, input int xk[$], input int xt[$],
                       input int ok[$], input int ot[$]);
    chk({nm, "_npulse"}, 64'(ok.size()), 64'(xk.size()));
    for (int i = 0; i < xk.size() && i < ok.size(); i++) begin
      chk({nm, "_pkind"}, 64'(ok[i]), 64'(xk[i]));
      chk({nm, "_pcyc"}, 64'(ot[i]), 64'(xt[i]));
    end
  endtask

  task automatic check_state(input string nm);
    chk({nm, " c_slot"}, 64'(c_slot), 64'(m_slot[0]));
    chk({nm, " c_ts"}, c_ts, m_ts[0]);
    chk({nm, " c_std"}, c_std, m_std[0]);
    chk({nm, " c_ret"}, c_ret, m_ret[0]);
    chk({nm, " c_fc"}, 64'(c_fc), 64'(m_fc));
    chk({nm, " c_ec"}, 64'(c_ec), 64'(m_ec));
    chk({nm, " t_slot"}, 64'(t_slot), 64'(m_slot[1]));
    chk({nm, " t_ts"}, t_ts, m_ts[1]);
    chk({nm, " t_std"}, t_std, m_std[1]);
    chk({nm, " t_ret"}, t_ret, m_ret[1]);
    chk({nm, " t_fc"}, 64'(t_fc), 64'(m_fc));
    chk({nm, " t_ec"}, 64'(t_ec), 64'(m_ec));
  endtask

  // idle a few cycles, then compare pulse history and held state
  task automatic check(input string nm);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (3) @(negedge clk);
    cmp_q({nm, " commit"}, xk0, xt0, ok0, ot0);
    cmp_q({nm, " cut"}, xk1, xt1, ok1, ot1);
    xk0.delete(); xt0.delete(); ok0.delete(); ot0.delete();
    xk1.delete(); xt1.delete(); ok1.delete(); ot1.delete();
    check_state(nm);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_slot[m] = '0; m_ts[m] = '0; m_std[m] = '0; m_ret[m] = '0;
    end
    m_fc = 0; m_ec = 0;
    xk0.delete(); xt0.delete(); xk1.delete(); xt1.delete();
  endtask

  task automatic check_pulses_low(input string nm);
    chk({nm, " c_pulses"}, 64'(pv0), 64'd0);
    chk({nm, " t_pulses"}, 64'(pv1), 64'd0);
  endtask

  initial begin
    bit          g;
    int          kd, n, pick;
    logic [63:0] b1, b2;
    bit          tu;

    tbl[0]  = '{4,  64'h0000_0000_ff03_0005, 64'h0,                   1'b0, 1'b1, 1};
    tbl[1]  = '{3,  64'h0000_0000_ff05_0066, 64'h0000_0123_4567_89ab, 1'b0, 1'b1, 3};
    tbl[2]  = '{3,  64'h0000_0000_ff05_0088, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 4};
    tbl[3]  = '{3,  64'h0000_0000_ff05_0055, 64'h5555_6666_7777_8888, 1'b0, 1'b1, 5};
    tbl[4]  = '{3,  64'h0000_0000_ff05_0088, 64'hdead_beef_0000_0001, 1'b1, 1'b0, 4};
    tbl[5]  = '{2,  64'h0000_0000_ff05_0066, 64'h0,                   1'b0, 1'b0, 3};
    tbl[6]  = '{10, 64'h0000_0000_ff05_0066, 64'haaaa_bbbb_cccc_dddd, 1'b0, 1'b0, 3};
    tbl[7]  = '{3,  64'h0000_0000_ff03_0006, 64'h0,                   1'b0, 1'b1, 1};
    tbl[8]  = '{2,  64'h0000_0000_ff0a_0000, 64'h0,                   1'b0, 1'b1, 2};
    tbl[9]  = '{5,  64'h0000_0000_ff0a_0000, 64'h0,                   1'b1, 1'b0, 2};
    tbl[10] = '{3,  64'h0000_0000_1234_0066, 64'h9999_9999_9999_9999, 1'b0, 1'b1, 0};
    tbl[11] = '{4,  64'h0000_0000_ff05_0012, 64'h7777_7777_7777_7777, 1'b0, 1'b1, 0};
    tbl[12] = '{1,  64'h0000_0000_ff03_0003, 64'h0,                   1'b0, 1'b0, 1};
    tbl[13] = '{8,  64'h0000_0000_ff05_0066, 64'h0102_0304_0506_0708, 1'b0, 1'b1, 3};
    tbl[14] = '{9,  64'h0000_0000_ff05_0055, 64'h0a0b_0c0d_0e0f_1011, 1'b0, 1'b0, 5};
    tbl[15] = '{2,  64'h0000_0000_4321_0000, 64'h0,                   1'b0, 1'b0, 0};
    tbl[16] = '{2,  64'hffff_ffff_ff03_fffd, 64'h0,                   1'b0, 1'b1, 1};

    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; tkeep = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_pulses_low("reset");
    check_state("reset");
    rst = 1'b0;

    // table vectors, each checked on its own
    for (int i = 0; i < 17; i++) begin
      send_frame(tbl[i].n, tbl[i].b1, tbl[i].b2, tbl[i].tu, 1'b1, tbl[i].good, tbl[i].kind);
      check($sformatf("vec%0d", i));
    end

    // back-to-back frames with no idle cycles
    send_frame(2, 64'h0000_0000_ff03_0001, 64'h0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(3, 64'h0000_0000_ff05_0066, 64'h1234_0000_0000_4321, 1'b0, 1'b0, 1'b1, 3);
    send_frame(1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(2, 64'h0000_0000_ff0a_0000, 64'h0, 1'b0, 1'b0, 1'b1, 2);
    check("b2b");

    // reset during beat2 of a timestamp frame
    @(negedge clk); tvalid = 1'b1; tlast = 1'b0; tuser = 1'b0; tdata = 64'h0;
    @(negedge clk); tdata = 64'h0000_0000_ff05_0066;
    @(negedge clk); tdata = 64'hfeed_face_cafe_beef; rst = 1'b1;
    @(negedge clk); tvalid = 1'b0;
    model_reset();
    check_pulses_low("midrst");
    check_state("midrst");
    @(negedge clk); rst = 1'b0;
    ok0.delete(); ot0.delete(); ok1.delete(); ot1.delete();
    send_frame(3, 64'h0000_0000_ff03_0002, 64'h0, 1'b0, 1'b1, 1'b1, 1);
    check("postrst");

    // randomized frames against the model
    for (int f = 0; f < 250; f++) begin
      n    = $urandom_range(1, 11);
      b1   = {$urandom, $urandom};
      b2   = {$urandom, $urandom};
      pick = $urandom_range(0, 4);
      b1[31:16] = (pick == 0) ? 16'hff03 : (pick == 1) ? 16'hff0a :
                  (pick == 4) ? 16'($urandom) : 16'hff05;
      pick = $urandom_range(0, 3);
      b1[7:0] = (pick == 0) ? 8'h66 : (pick == 1) ? 8'h88 : (pick == 2) ? 8'h55 : 8'($urandom);
      tu = ($urandom_range(0, 7) == 0);
      model(n, b1, tu, g, kd);
      send_frame(n, b1, b2, tu, 1'($urandom_range(0, 1)), g, kd);
      if (f % 4 == 3) check($sformatf("rnd%0d", f));
    end
    check("rnd_end");

    // counter saturation: preload near the top, then push past it
    @(negedge clk);
    force dut_c.frame_cnt_q = 16'hfffd;
    force dut_t.frame_cnt_q = 16'hfffd;
    force dut_c.err_cnt_q   = 16'hfffe;
    force dut_t.err_cnt_q   = 16'hfffe;
    @(negedge clk);
    release dut_c.frame_cnt_q;
    release dut_t.frame_cnt_q;
    release dut_c.err_cnt_q;
    release dut_t.err_cnt_q;
    m_fc = 16'hfffd;
    m_ec = 16'hfffe;
    check("preload");
    for (int i = 0; i < 3; i++) begin
      send_frame(2, 64'h0000_0000_ff03_0004, 64'h0, 1'b0, 1'b0, 1'b1, 1);
      send_frame(1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 0);
    end
    check("sat");
    chk("sat c_fc_top", 64'(c_fc), 64'hffff);
    chk("sat c_ec_top", 64'(c_ec), 64'hffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_frame_rx_parser.md
Name: ctrl_frame_rx_parser

Overview:
- Parametrised successor of the control-port time-sync receiver.
- Parses 64-bit AXIS control frames from the controller: slot-ID frames, sim-start frames and time-sync frames (timestamp, standard time, return timestamp).
- Adds frame-level validation: runt, oversize and tuser-error frames are dropped. Adds a selectable commit mode, where outputs are released only after a clean tlast.
- Adds saturating good-frame and error-frame counters. Sits between the controller RX MAC/AXIS path and the ToR slot/time-sync logic.

Parameters:
- P_SLOT_ID_TYPE, 16'hff03, type field value of a slot-ID frame
- P_SIM_START, 16'hff0a, type field value of a sim-start frame
- P_TIME_TYPE, 16'hff05, type field value of a time-sync frame
- P_TS_CODE, 8'h66, sub-code for timestamp
- P_STD_CODE, 8'h88, sub-code for standard time
- P_RET_CODE, 8'h55, sub-code for return timestamp
- P_SLOT_ID_W, 3, width of the slot ID taken from beat1[P_SLOT_ID_W-1:0] (valid range 1..16)
- P_MAX_BEATS, 8, maximum legal frame length in beats (valid range 3..255)
- P_COMMIT_ON_LAST, 1, 1 = outputs pulse only after clean tlast; 0 = cut-through on the decisive beat

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, asynchronous active-high reset
- s_ctrl_rx_axis_tvalid, in, 1, beat valid (no tready; the sink always accepts)
- s_ctrl_rx_axis_tdata, in, 64, beat data
- s_ctrl_rx_axis_tlast, in, 1, last beat
- s_ctrl_rx_axis_tkeep, in, 8, byte enables (ignored except as noted)
- s_ctrl_rx_axis_tuser, in, 1, error flag, sampled on the tlast beat
- o_cur_slot_id, out, P_SLOT_ID_W, last committed slot ID (held)
- o_syn_start, out, 1, 1-cycle pulse on slot-ID commit
- o_sim_start, out, 1, 1-cycle pulse on sim-start commit
- o_recv_time_stamp, out, 64, timestamp value (held)
- o_recv_ts_valid, out, 1, 1-cycle pulse
- o_recv_std_time, out, 64, standard time value (held)
- o_recv_std_valid, out, 1, 1-cycle pulse
- o_recv_return_ts, out, 64, return timestamp value (held)
- o_recv_return_valid, out, 1, 1-cycle pulse
- o_frame_cnt, out, 16, good frames, saturates at 16'hffff
- o_err_cnt, out, 16, dropped frames, saturates at 16'hffff

Behaviour:
- Frame layout:
  - beat0: MAC header.
  - beat1: [31:16] type, [7:0] sub-code (time-sync frames), [P_SLOT_ID_W-1:0] slot ID (slot frames).
  - beat2: 64-bit time value (time-sync frames only). Further beats are padding.
- Beat counter: 8-bit, counts accepted beats within a frame, cleared on tlast. tvalid gaps are allowed anywhere; state is held while tvalid=0.
- FSM states:
  - IDLE: first beat moves to HDR. A beat with tlast in IDLE is a runt: error, stay IDLE.
  - HDR: beat1 decodes type and sub-code into shadow registers, then moves to BODY. tlast on beat1 is a runt unless type is slot-ID or sim-start (minimum length 2 beats for those); a valid 2-beat frame commits.
  - BODY: beat2 captures the time value into the shadow register. tlast commits. Reaching beat P_MAX_BEATS without tlast moves to DROP.
  - DROP: discards beats until tlast, counts one error, returns to IDLE.
- Minimum length:
  - Time-sync frames need 3 beats; shorter is a runt.
  - Unknown type or unknown sub-code is a good frame with no output pulse.
- Commit mode (P_COMMIT_ON_LAST=1):
  - On the tlast beat with tuser=0 and no runt/oversize, the frame is good. In the following cycle: o_frame_cnt+1, the matching valid pulse fires, and the held value or slot ID is updated.
  - tuser=1 on tlast: frame is dropped, o_err_cnt+1, no pulse, held values unchanged.
- Cut-through mode (P_COMMIT_ON_LAST=0):
  - Slot/sim pulses fire one cycle after beat1; time pulses fire one cycle after beat2, with the value updated that same cycle.
  - tuser and oversize still drive the counters at tlast; pulses already issued are not retracted.
- Each valid pulse is exactly 1 cycle; at most one pulse per frame.
- Counters:
  - Each frame increments exactly one counter. Both saturate at 16'hffff and never wrap.
  - A frame-end (tlast) beat and a start-of-frame beat cannot fall in the same cycle; back-to-back frames with zero idle cycles are supported.
- Reset (any time, including mid-frame):
  - All outputs go to 0, counters to 0, FSM to IDLE, shadow registers cleared.
  - The first beat after reset release is treated as beat0.
- tkeep: a tlast beat with tkeep=0 is still a valid end of frame.

Test Plan:
- Slot frame, 4 beats, beat1[31:16]=ff03, [2:0]=5, tuser=0 -> cycle after tlast: o_syn_start=1 for 1 cycle, o_cur_slot_id=5, o_frame_cnt=1.
- Timestamp frame, 3 beats, beat1 type ff05 code 66, beat2=64'h0000_0123_4567_89ab -> o_recv_ts_valid pulse, o_recv_time_stamp=64'h0000_0123_4567_89ab. Repeat with code 88 and 55 -> std/return outputs only.
- Std-time frame with tuser=1 on tlast -> no pulse, o_recv_std_time unchanged, o_err_cnt=1.
- 2-beat time-sync frame (runt), then a 10-beat frame with P_MAX_BEATS=8 -> o_err_cnt=2, no pulses, next clean slot frame commits normally.
- P_COMMIT_ON_LAST=0: sim-start frame ff0a -> o_sim_start pulses one cycle after beat1, before tlast. tuser=1 at end -> o_err_cnt+1, pulse not retracted.
- Assert i_rst during beat2 of a timestamp frame, release, send a slot frame with ID 2 -> all outputs 0 during reset, no ts pulse, o_cur_slot_id=2 and o_frame_cnt=1. Force 65536+ good frames -> o_frame_cnt holds at ffff.
